// File: rtl/nes_pad_reader.sv
// NES gamepad poller: drives latch/clock to a 4021 pad and shifts in 8 buttons.
// Publishes an active-high snapshot and a 5-bit CPU view once per frame.
module nes_pad_reader #(
    parameter logic [15:0] POLL_CYCLES  = 16'd50000,
    parameter logic [15:0] LATCH_CYCLES = 16'd600,
    parameter logic [15:0] HALF_CYCLES  = 16'd300
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pad_data,
    output logic       pad_latch,
    output logic       pad_clk,
    output logic [7:0] buttons,
    output logic [4:0] controller_out,
    output logic       frame_valid
);

    typedef enum logic [2:0] {
        IDLE,
        LATCH,
        SETTLE,
        CLK_HI,
        CLK_LO,
        DONE
    } state_t;

    state_t      state;
    logic [15:0] cnt;
    logic [2:0]  idx;
    logic [7:0]  shift;
    logic        sync1;
    logic        sync2;
    logic        last;
    logic [7:0]  shift_fin;

    assign last = (cnt == 16'd1);

    // Shift register as it will look once the current bit is captured
    always_comb begin
        shift_fin      = shift;
        shift_fin[idx] = sync2;
    end

    // Two-flop synchronizer for the asynchronous pad data line
    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= pad_data;
            sync2 <= sync1;
        end
    end

    // Poll sequencer; a zero counter in IDLE only occurs right after reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            state          <= IDLE;
            cnt            <= 16'd0;
            idx            <= 3'd0;
            shift          <= 8'h00;
            pad_latch      <= 1'b0;
            pad_clk        <= 1'b0;
            buttons        <= 8'h00;
            controller_out <= 5'h00;
            frame_valid    <= 1'b0;
        end else begin
            frame_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (cnt == 16'd0) begin
                        cnt <= POLL_CYCLES;
                    end else if (last) begin
                        state     <= LATCH;
                        cnt       <= LATCH_CYCLES;
                        pad_latch <= 1'b1;
                    end else begin
                        cnt <= cnt - 16'd1;
                    end
                end
                LATCH: begin
                    if (last) begin
                        state     <= SETTLE;
                        cnt       <= HALF_CYCLES;
                        pad_latch <= 1'b0;
                    end else begin
                        cnt <= cnt - 16'd1;
                    end
                end
                SETTLE: begin
                    if (last) begin
                        shift[0] <= sync2;
                        idx      <= 3'd1;
                        state    <= CLK_HI;
                        cnt      <= HALF_CYCLES;
                        pad_clk  <= 1'b1;
                    end else begin
                        cnt <= cnt - 16'd1;
                    end
                end
                CLK_HI: begin
                    if (last) begin
                        state   <= CLK_LO;
                        cnt     <= HALF_CYCLES;
                        pad_clk <= 1'b0;
                    end else begin
                        cnt <= cnt - 16'd1;
                    end
                end
                CLK_LO: begin
                    if (last) begin
                        shift <= shift_fin;
                        if (idx == 3'd7) begin
                            state          <= DONE;
                            cnt            <= 16'd1;
                            buttons        <= ~shift_fin;
                            controller_out <= {~shift_fin[0], ~shift_fin[4],
                                               ~shift_fin[5], ~shift_fin[6],
                                               ~shift_fin[7]};
                            frame_valid    <= 1'b1;
                        end else begin
                            idx     <= idx + 3'd1;
                            state   <= CLK_HI;
                            cnt     <= HALF_CYCLES;
                            pad_clk <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt - 16'd1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    cnt   <= POLL_CYCLES;
                    idx   <= 3'd0;
                end
                default: begin
                    state     <= IDLE;
                    cnt       <= 16'd0;
                    pad_latch <= 1'b0;
                    pad_clk   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nes_pad_reader.sv
// Bench for nes_pad_reader with a behavioural 4021 pad model.
// Directed frames plus a short random run, all checked against local expectations.
module tb_nes_pad_reader;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       pad_data;
    logic       pad_latch;
    logic       pad_clk;
    logic [7:0] buttons;
    logic [4:0] controller_out;
    logic       frame_valid;

    int checks = 0;
    int errors = 0;

    logic [7:0] pat = 8'h00;
    logic [7:0] sr = 8'hFF;
    logic [7:0] exp_b = 8'h00;
    logic       pclk_d = 1'b0;

    int   rises = 0;
    int   fv_count = 0;
    logic prev_rst = 1'b0;
    logic prev_fv = 1'b0;
    logic prev_pclk = 1'b0;
    logic [7:0] prev_b = 8'h00;
    logic [4:0] prev_c = 5'h00;

    nes_pad_reader #(
        .POLL_CYCLES (16'd20),
        .LATCH_CYCLES(16'd4),
        .HALF_CYCLES (16'd4)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .pad_data      (pad_data),
        .pad_latch     (pad_latch),
        .pad_clk       (pad_clk),
        .buttons       (buttons),
        .controller_out(controller_out),
        .frame_valid   (frame_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [4:0] ctrl_of(input logic [7:0] b);
        return {b[0], b[4], b[5], b[6], b[7]};
    endfunction

    // 4021 model: parallel load while latch high, shift on pad_clk rise
    assign pad_data = sr[0];
    always @(posedge clk) begin
        if (pad_latch) begin
            sr    <= ~pat;
            exp_b <= pat;
        end else if (pad_clk && !pclk_d) begin
            sr <= {1'b1, sr[7:1]};
        end
        pclk_d <= pad_clk;
    end

    // Continuous monitors: exclusivity, pulse count, scoreboard, hold
    always @(negedge clk) begin
        if (reset) begin
            check("overlap", pad_latch & pad_clk, 1'b0);
            check("fv_pair", frame_valid & prev_fv, 1'b0);
            if (pad_clk && !prev_pclk) rises++;
            if (frame_valid) begin
                check("edges", rises, 7);
                check("sb_btn", buttons, exp_b);
                check("sb_ctrl", controller_out, ctrl_of(exp_b));
                rises = 0;
                fv_count++;
            end else if (prev_rst) begin
                check("hold_btn", buttons, prev_b);
                check("hold_ctrl", controller_out, prev_c);
            end
        end else begin
            rises = 0;
        end
        prev_rst  = reset;
        prev_fv   = frame_valid;
        prev_pclk = pad_clk;
        prev_b    = buttons;
        prev_c    = controller_out;
    end

    task automatic wait_fv();
        logic found = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (frame_valid) begin
                found = 1'b1;
                break;
            end
        end
        check("fv_wait", found, 1'b1);
    endtask

    task automatic wait_latch();
        logic found = 1'b0;
        logic prv = pad_latch;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (pad_latch && !prv) begin
                found = 1'b1;
                break;
            end
            prv = pad_latch;
        end
        check("latch_wait", found, 1'b1);
    endtask

    task automatic wait_pclk(input logic rise, input int n);
        int   seen = 0;
        logic prv = pad_clk;
        for (int i = 0; i < 400 && seen < n; i++) begin
            @(negedge clk);
            if (rise ? (pad_clk && !prv) : (!pad_clk && prv)) seen++;
            prv = pad_clk;
        end
        check("pclk_wait", seen, n);
    endtask

    task automatic expect_out(input string tag, input logic [7:0] b,
                              input logic [4:0] c);
        check({tag, "_btn"}, buttons, b);
        check({tag, "_ctrl"}, controller_out, c);
    endtask

    initial begin
        int   latch_cnt;
        int   nrise;
        int   hi_run;
        int   lo_run;
        int   fv_at;
        int   fvc0;
        logic prv;

        // Reset holds everything low
        reset = 1'b0;
        pat   = 8'h00;
        repeat (5) @(negedge clk);
        expect_out("rst", 8'h00, 5'h00);
        check("rst_latch", pad_latch, 1'b0);
        check("rst_pclk", pad_clk, 1'b0);
        check("rst_fv", frame_valid, 1'b0);

        // First frame timing after release
        reset = 1'b1;
        repeat (20) @(negedge clk);
        check("idle_latch", pad_latch, 1'b0);
        @(negedge clk);
        check("latch_rise", pad_latch, 1'b1);
        latch_cnt = 1;
        nrise     = 0;
        hi_run    = 0;
        lo_run    = 0;
        fv_at     = 0;
        prv       = pad_clk;
        for (int i = 2; i <= 100; i++) begin
            @(negedge clk);
            if (pad_latch) latch_cnt++;
            if (pad_clk && !prv) begin
                nrise++;
                if (nrise > 1) check("clk_lo_len", lo_run, 4);
                hi_run = 1;
            end else if (pad_clk) begin
                hi_run++;
            end else if (prv) begin
                check("clk_hi_len", hi_run, 4);
                lo_run = 1;
            end else begin
                lo_run++;
            end
            prv = pad_clk;
            if (frame_valid) begin
                fv_at = i;
                break;
            end
        end
        check("latch_len", latch_cnt, 4);
        check("clk_pulses", nrise, 7);
        check("fv_at", fv_at, 65);
        expect_out("none", 8'h00, 5'h00);

        // A + Right
        pat = 8'h81;
        wait_fv();
        expect_out("a_right", 8'h81, 5'b10001);
        @(negedge clk);
        check("fv_one", frame_valid, 1'b0);

        // Released pad after a pressed frame
        pat = 8'h00;
        wait_fv();
        expect_out("release", 8'h00, 5'h00);
        repeat (10) @(negedge clk);
        expect_out("idle_hold", 8'h00, 5'h00);

        // Pad changes mid-frame: latched value wins
        pat = 8'h10;
        wait_latch();
        wait_pclk(1'b1, 2);
        pat = 8'h20;
        wait_fv();
        expect_out("up", 8'h10, 5'b01000);
        wait_fv();
        expect_out("down", 8'h20, 5'b00100);

        // All pressed, then reset during CLK_LO of bit 5
        pat = 8'hFF;
        wait_fv();
        expect_out("all", 8'hFF, 5'h1F);
        wait_latch();
        wait_pclk(1'b1, 5);
        wait_pclk(1'b0, 1);
        reset = 1'b0;
        fvc0  = fv_count;
        repeat (3) @(negedge clk);
        expect_out("midrst", 8'h00, 5'h00);
        check("midrst_fv", frame_valid, 1'b0);
        check("midrst_latch", pad_latch, 1'b0);
        check("midrst_pclk", pad_clk, 1'b0);
        pat   = 8'h42;
        reset = 1'b1;
        wait_latch();
        check("no_fv", fv_count, fvc0);
        wait_fv();
        expect_out("post_rst", 8'h42, 5'b00010);

        // Random frames
        for (int f = 0; f < 10; f++) begin
            pat = 8'($urandom_range(0, 255));
            wait_fv();
            expect_out("rand", pat, ctrl_of(pat));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
